// File: rtl/data_stream_pkg.sv
// Shared types and timing helpers for the data stream multiplexer/demultiplexer pair.
package data_stream_pkg;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_1   = 2'd1,
        MODE_2   = 2'd2,
        MODE_3   = 2'd3
    } mode_t;

    typedef enum logic {
        TIMER_IDLE = 1'b0,
        TIMER_RUN  = 1'b1
    } timer_state_t;

    // Number of system clock cycles in one symbol period.
    function automatic int unsigned cycles_per_symbol(input int unsigned clk_f,
                                                      input int unsigned symbol_clk_f);
        return clk_f / symbol_clk_f;
    endfunction

    // Centre-of-slot sample point (slot is 0-based) for a symbol of n cycles.
    function automatic int unsigned slot_sample(input int unsigned n,
                                                input mode_t       mode,
                                                input int unsigned slot);
        int unsigned s;
        s = 0;
        case (mode)
            MODE_1: s = n / 2;
            MODE_2: s = (slot == 0) ? (n / 4) : (n / 2 + n / 4);
            MODE_3: begin
                if (slot == 0)      s = n / 6;
                else if (slot == 1) s = n / 3 + n / 6;
                else                s = (2 * n) / 3 + n / 6;
            end
            default: s = 0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/data_stream_demultiplexer_symbol_timer.sv
// Symbol timing recovery: symbol_clk edge detect, IDLE/RUN state, slot counter and
// per-symbol mode latch.
module symbol_timer
    import data_stream_pkg::*;
#(
    parameter int unsigned n     = 100,
    parameter int unsigned cnt_w = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             symbol_clk,
    input  mode_t            mode,
    output logic [cnt_w-1:0] cnt,
    output mode_t            mode_l,
    output logic             sym_end,
    output logic             early_edge
);

    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(n - 1);

    timer_state_t state;
    logic         sym_prev;
    logic         sym_rise;
    logic         at_last;

    assign sym_rise   = symbol_clk & ~sym_prev;
    assign at_last    = (cnt == cnt_last);
    assign sym_end    = (state == TIMER_RUN) && at_last;
    assign early_edge = (state == TIMER_RUN) && sym_rise && !at_last;

    // State, counter and mode latch; a new edge or a wrap both start a fresh symbol.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= TIMER_IDLE;
            cnt      <= '0;
            sym_prev <= 1'b0;
            mode_l   <= MODE_OFF;
        end else begin
            sym_prev <= symbol_clk;
            case (state)
                TIMER_IDLE: begin
                    cnt <= '0;
                    if (sym_rise) begin
                        state  <= TIMER_RUN;
                        mode_l <= mode;
                    end
                end
                TIMER_RUN: begin
                    if (sym_rise || at_last) begin
                        cnt    <= '0;
                        mode_l <= mode;
                    end else begin
                        cnt <= cnt + cnt_w'(1);
                    end
                end
                default: state <= TIMER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/data_stream_demultiplexer.sv
// TDM demultiplexer: samples each slot at its centre and presents ds1..ds3 once per symbol.
// Optional build macro DEMUX_SYNC_CHECK_EN enables the sticky sync_err early-edge flag.
module data_stream_demultiplexer
    import data_stream_pkg::*;
#(
    parameter int unsigned symbol_clk_f = 1_000_000,
    parameter int unsigned clk_f        = 100_000_000,
    parameter int unsigned ds_width     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                symbol_clk,
    input  logic [1:0]          mode,
    input  logic [ds_width-1:0] multiplexed_data,
    output logic [ds_width-1:0] ds1_out,
    output logic [ds_width-1:0] ds2_out,
    output logic [ds_width-1:0] ds3_out,
    output logic                ds_valid,
    output logic                sync_err
);

    localparam int unsigned n     = cycles_per_symbol(clk_f, symbol_clk_f);
    localparam int unsigned cnt_w = $clog2(n);

    localparam logic [cnt_w-1:0] s_m1   = cnt_w'(slot_sample(n, MODE_1, 0));
    localparam logic [cnt_w-1:0] s_m2_0 = cnt_w'(slot_sample(n, MODE_2, 0));
    localparam logic [cnt_w-1:0] s_m2_1 = cnt_w'(slot_sample(n, MODE_2, 1));
    localparam logic [cnt_w-1:0] s_m3_0 = cnt_w'(slot_sample(n, MODE_3, 0));
    localparam logic [cnt_w-1:0] s_m3_1 = cnt_w'(slot_sample(n, MODE_3, 1));
    localparam logic [cnt_w-1:0] s_m3_2 = cnt_w'(slot_sample(n, MODE_3, 2));

    logic [cnt_w-1:0]    cnt;
    mode_t               mode_l;
    logic                sym_end;
    logic                early_edge;
    logic [ds_width-1:0] sh1;
    logic [ds_width-1:0] sh2;
    logic [ds_width-1:0] sh3;

    symbol_timer #(
        .n     (n),
        .cnt_w (cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .symbol_clk (symbol_clk),
        .mode       (mode_t'(mode)),
        .cnt        (cnt),
        .mode_l     (mode_l),
        .sym_end    (sym_end),
        .early_edge (early_edge)
    );

    // Capture each slot centre into its shadow; an early edge throws the partial symbol away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh1 <= '0;
            sh2 <= '0;
            sh3 <= '0;
        end else if (early_edge) begin
            sh1 <= '0;
            sh2 <= '0;
            sh3 <= '0;
        end else begin
            case (mode_l)
                MODE_1: begin
                    if (cnt == s_m1) sh1 <= multiplexed_data;
                end
                MODE_2: begin
                    if (cnt == s_m2_0) sh1 <= multiplexed_data;
                    if (cnt == s_m2_1) sh2 <= multiplexed_data;
                end
                MODE_3: begin
                    if (cnt == s_m3_0) sh1 <= multiplexed_data;
                    if (cnt == s_m3_1) sh2 <= multiplexed_data;
                    if (cnt == s_m3_2) sh3 <= multiplexed_data;
                end
                default: ;
            endcase
        end
    end

    // End-of-symbol transfer of shadows to outputs with a one-cycle valid strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ds1_out  <= '0;
            ds2_out  <= '0;
            ds3_out  <= '0;
            ds_valid <= 1'b0;
        end else begin
            ds_valid <= 1'b0;
            if (sym_end && (mode_l != MODE_OFF)) begin
                ds_valid <= 1'b1;
                ds1_out  <= sh1;
                ds2_out  <= (mode_l == MODE_1) ? '0 : sh2;
                ds3_out  <= (mode_l == MODE_3) ? sh3 : '0;
            end
        end
    end

`ifdef DEMUX_SYNC_CHECK_EN
    // Sticky flag for a symbol edge arriving before the counter reached its last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_err <= 1'b0;
        end else if (early_edge) begin
            sync_err <= 1'b1;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_stream_demultiplexer.sv
// Self-checking bench for data_stream_demultiplexer (N = 100, 8-bit streams).
module tb_data_stream_demultiplexer;

    localparam int N = 100;

`ifdef DEMUX_SYNC_CHECK_EN
    localparam logic SYNC_EXP = 1'b1;
`else
    localparam logic SYNC_EXP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       symbol_clk;
    logic [1:0] mode;
    logic [7:0] multiplexed_data;
    logic [7:0] ds1_out;
    logic [7:0] ds2_out;
    logic [7:0] ds3_out;
    logic       ds_valid;
    logic       sync_err;

    data_stream_demultiplexer dut (
        .clk              (clk),
        .rst              (rst),
        .symbol_clk       (symbol_clk),
        .mode             (mode),
        .multiplexed_data (multiplexed_data),
        .ds1_out          (ds1_out),
        .ds2_out          (ds2_out),
        .ds3_out          (ds3_out),
        .ds_valid         (ds_valid),
        .sync_err         (sync_err)
    );

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         mon_edges = 0;
    int         n_valid = 0;
    logic [7:0] held1 = 8'h00;
    logic [7:0] held2 = 8'h00;
    logic [7:0] held3 = 8'h00;

    // Upstream model state: phase p (0 = symbol_clk rising cycle), words for the current symbol
    int         p;
    int         seg_len;
    int         inject_at = -1;
    int         last_c;
    logic [1:0] tx_mode;
    logic [7:0] w1, w2, w3;
    logic [7:0] tx1, tx2, tx3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream word for counter value c: slot word only at its centre, noise elsewhere.
    function automatic logic [7:0] upstream(input logic [1:0] m, input int c,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] d);
        logic [7:0] v;
        v = 8'($urandom);
        case (m)
            2'd1: if (c == 50) v = a;
            2'd2: begin
                if (c == 25) v = a;
                if (c == 75) v = b;
            end
            2'd3: begin
                if (c == 16) v = a;
                if (c == 49) v = b;
                if (c == 82) v = d;
            end
            default: ;
        endcase
        return v;
    endfunction

    // One input cycle: drive at negedge; at each aligned symbol end push the expected words.
    task automatic drive_cycle();
        exp_t e;
        int   c;
        @(negedge clk);
        if (inject_at >= 0 && p == inject_at) begin
            p = 0;
            inject_at = -1;
        end
        if (p == 0) begin
            if (seg_len == N && tx_mode != 2'd0) begin
                e.d1  = tx1;
                e.d2  = (tx_mode >= 2'd2) ? tx2 : 8'h00;
                e.d3  = (tx_mode == 2'd3) ? tx3 : 8'h00;
                e.due = mon_edges + 1;
                exp_q.push_back(e);
            end
            seg_len = (rst === 1'b1) ? 0 : -100000;
            tx_mode = mode;
            tx1 = w1;
            tx2 = w2;
            tx3 = w3;
        end
        symbol_clk = (p < N / 2);
        c = (p + N - 1) % N;
        last_c = c;
        multiplexed_data = upstream(tx_mode, c, tx1, tx2, tx3);
        p = (p + 1) % N;
        seg_len++;
    endtask

    task automatic run_cycles(input int k);
        repeat (k) drive_cycle();
    endtask

    task automatic wait_cnt(input int target);
        int k;
        k = 0;
        do begin
            drive_cycle();
            k++;
        end while (last_c != target && k < 2 * N);
        checks++;
        if (last_c != target) begin
            errors++;
            $display("FAIL wait_cnt: reached %0d, required %0d", last_c, target);
        end
    endtask

    // Scoreboard monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        mon_edges++;
        if (ds_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: edge %0d outs %h %h %h", mon_edges,
                         ds1_out, ds2_out, ds3_out);
            end else begin
                e = exp_q.pop_front();
                if ({ds1_out, ds2_out, ds3_out} !== {e.d1, e.d2, e.d3} || e.due != mon_edges) begin
                    errors++;
                    $display("FAIL valid_data: got %h %h %h at edge %0d, required %h %h %h at edge %0d",
                             ds1_out, ds2_out, ds3_out, mon_edges, e.d1, e.d2, e.d3, e.due);
                end
                held1 = e.d1;
                held2 = e.d2;
                held3 = e.d3;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= mon_edges) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missing_valid: no strobe at edge %0d, required %h %h %h",
                         mon_edges, e.d1, e.d2, e.d3);
            end
            checks++;
            if ({ds1_out, ds2_out, ds3_out} !== {held1, held2, held3}) begin
                errors++;
                $display("FAIL hold: got %h %h %h, required %h %h %h at edge %0d",
                         ds1_out, ds2_out, ds3_out, held1, held2, held3, mon_edges);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        p = 60;
        seg_len = -100000;
        tx_mode = 2'd0;
        w1 = 8'h00; w2 = 8'h00; w3 = 8'h00;
        tx1 = 8'h00; tx2 = 8'h00; tx3 = 8'h00;
        symbol_clk = 1'b0;
        mode = 2'd0;
        multiplexed_data = 8'h00;
        #2 rst = 1'b0;
        run_cycles(10);
        checks++;
        if ({ds1_out, ds2_out, ds3_out, ds_valid, sync_err} !== 26'h0) begin
            errors++;
            $display("FAIL reset_state: got %h %h %h v=%b e=%b, required all 0",
                     ds1_out, ds2_out, ds3_out, ds_valid, sync_err);
        end
        mode = 2'd3;
        w1 = 8'hA1; w2 = 8'hB2; w3 = 8'hC3;
        rst = 1'b1;
    endtask

    task automatic test_mode3();
        int nv0;
        nv0 = n_valid;
        run_cycles(4 * N);
        checks++;
        if (n_valid - nv0 != 3) begin
            errors++;
            $display("FAIL mode3_count: got %0d strobes, required 3", n_valid - nv0);
        end
        checks++;
        if ({ds1_out, ds2_out, ds3_out} !== 24'hA1B2C3) begin
            errors++;
            $display("FAIL mode3_data: got %h %h %h, required a1 b2 c3", ds1_out, ds2_out, ds3_out);
        end
    endtask

    task automatic test_mode2_mode1();
        int nv0;
        mode = 2'd2;
        w1 = 8'h11; w2 = 8'h22;
        nv0 = n_valid;
        run_cycles(3 * N);
        checks++;
        if (n_valid - nv0 != 3 || {ds1_out, ds2_out, ds3_out} !== 24'h112200) begin
            errors++;
            $display("FAIL mode2: got %h %h %h (%0d strobes), required 11 22 00 (3 strobes)",
                     ds1_out, ds2_out, ds3_out, n_valid - nv0);
        end
        mode = 2'd1;
        w1 = 8'h5A;
        nv0 = n_valid;
        run_cycles(3 * N);
        checks++;
        if (n_valid - nv0 != 3 || {ds1_out, ds2_out, ds3_out} !== 24'h5A0000) begin
            errors++;
            $display("FAIL mode1: got %h %h %h (%0d strobes), required 5a 00 00 (3 strobes)",
                     ds1_out, ds2_out, ds3_out, n_valid - nv0);
        end
    endtask

    task automatic test_mode_switch();
        mode = 2'd2;
        w1 = 8'h33; w2 = 8'h44; w3 = 8'h55;
        run_cycles(2 * N);
        wait_cnt(40);
        mode = 2'd3;
        run_cycles(62);
        checks++;
        if ({ds1_out, ds2_out, ds3_out} !== 24'h334400) begin
            errors++;
            $display("FAIL switch_current: got %h %h %h, required 33 44 00", ds1_out, ds2_out, ds3_out);
        end
        run_cycles(N);
        checks++;
        if ({ds1_out, ds2_out, ds3_out} !== 24'h334455) begin
            errors++;
            $display("FAIL switch_next: got %h %h %h, required 33 44 55", ds1_out, ds2_out, ds3_out);
        end
    endtask

    task automatic test_early_edge();
        int nv0;
        mode = 2'd3;
        w1 = 8'h66; w2 = 8'h77; w3 = 8'h88;
        run_cycles(2 * N);
        checks++;
        if (sync_err !== 1'b0 || {ds1_out, ds2_out, ds3_out} !== 24'h667788) begin
            errors++;
            $display("FAIL pre_early: got %h %h %h err=%b, required 66 77 88 err=0",
                     ds1_out, ds2_out, ds3_out, sync_err);
        end
        wait_cnt(55);
        w1 = 8'h99; w2 = 8'hAA; w3 = 8'hBB;
        inject_at = 61;
        nv0 = n_valid;
        run_cycles(7);
        checks++;
        if (sync_err !== SYNC_EXP) begin
            errors++;
            $display("FAIL sync_err_set: got %b, required %b", sync_err, SYNC_EXP);
        end
        run_cycles(95);
        checks++;
        if (n_valid != nv0 || {ds1_out, ds2_out, ds3_out} !== 24'h667788) begin
            errors++;
            $display("FAIL early_discard: got %h %h %h (%0d strobes), required 66 77 88 (0 strobes)",
                     ds1_out, ds2_out, ds3_out, n_valid - nv0);
        end
        run_cycles(5);
        checks++;
        if (n_valid != nv0 + 1 || {ds1_out, ds2_out, ds3_out} !== 24'h99AABB || sync_err !== SYNC_EXP) begin
            errors++;
            $display("FAIL early_recover: got %h %h %h err=%b (%0d strobes), required 99 aa bb err=%b (1 strobe)",
                     ds1_out, ds2_out, ds3_out, sync_err, n_valid - nv0, SYNC_EXP);
        end
    endtask

    task automatic test_reset_mid_symbol();
        int nv0;
        mode = 2'd3;
        w1 = 8'h12; w2 = 8'h34; w3 = 8'h56;
        run_cycles(2 * N);
        wait_cnt(30);
        rst = 1'b0;
        #1;
        checks++;
        if ({ds1_out, ds2_out, ds3_out, ds_valid, sync_err} !== 26'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h %h %h v=%b e=%b, required all 0",
                     ds1_out, ds2_out, ds3_out, ds_valid, sync_err);
        end
        held1 = 8'h00; held2 = 8'h00; held3 = 8'h00;
        exp_q.delete();
        seg_len = -100000;
        run_cycles(30);
        rst = 1'b1;
        nv0 = n_valid;
        run_cycles(137);
        checks++;
        if (n_valid != nv0 || {ds1_out, ds2_out, ds3_out} !== 24'h0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %h %h %h (%0d strobes), required 00 00 00 (0 strobes)",
                     ds1_out, ds2_out, ds3_out, n_valid - nv0);
        end
        run_cycles(3);
        checks++;
        if (n_valid != nv0 + 1 || {ds1_out, ds2_out, ds3_out} !== 24'h123456 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first: got %h %h %h err=%b (%0d strobes), required 12 34 56 err=0 (1 strobe)",
                     ds1_out, ds2_out, ds3_out, sync_err, n_valid - nv0);
        end
    endtask

    task automatic test_mode_off();
        int nv0;
        mode = 2'd0;
        run_cycles(N + 5);
        nv0 = n_valid;
        run_cycles(3 * N);
        checks++;
        if (n_valid != nv0 || {ds1_out, ds2_out, ds3_out} !== 24'h123456) begin
            errors++;
            $display("FAIL mode_off_hold: got %h %h %h (%0d strobes), required 12 34 56 (0 strobes)",
                     ds1_out, ds2_out, ds3_out, n_valid - nv0);
        end
        mode = 2'd3;
        w1 = 8'hDE; w2 = 8'hAD; w3 = 8'hBE;
        run_cycles(2 * N + 5);
        checks++;
        if ({ds1_out, ds2_out, ds3_out} !== 24'hDEADBE) begin
            errors++;
            $display("FAIL mode_off_resume: got %h %h %h, required de ad be", ds1_out, ds2_out, ds3_out);
        end
        run_cycles(N);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected strobes outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mode3();
        test_mode2_mode1();
        test_mode_switch();
        test_early_edge();
        test_reset_mid_symbol();
        test_mode_off();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_stream_demultiplexer.md
Name: data_stream_demultiplexer

Overview:
Downstream stage of data_stream_multiplexer. It takes the time-division-multiplexed word stream and the same symbol_clk, recovers per-symbol slot timing with a local cycle counter, and samples each slot at its centre. The recovered ds1..ds3 words are presented once per symbol with a one-cycle valid strobe for the consumer.

Parameters:
symbol_clk_f, 1_000_000, symbol rate in Hz
clk_f, 100_000_000, system clock rate in Hz; N = clk_f/symbol_clk_f clock cycles per symbol (N >= 6)
ds_width, 8, width of each data stream word

Ports:
clk  in  1  system clock; all logic on posedge clk
rst  in  1  reset; asynchronous, active-low
symbol_clk  in  1  symbol clock, level input; its rising edge marks symbol start
mode  in  2  0=off, 1=ds1 only, 2=ds1/ds2 halves, 3=ds1/ds2/ds3 thirds
multiplexed_data  in  ds_width  TDM word stream from the upstream multiplexer
ds1_out  out  ds_width  recovered stream 1
ds2_out  out  ds_width  recovered stream 2
ds3_out  out  ds_width  recovered stream 3
ds_valid  out  1  one-cycle strobe; ds*_out updated this cycle
sync_err  out  1  sticky symbol-timing error flag (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, cnt=0, sym_prev=0, mode_l=0, shadows=0. ds1_out/ds2_out/ds3_out=0, ds_valid=0, sync_err=0.
- Edge detect: sym_rise = symbol_clk & ~sym_prev, where sym_prev is registered every cycle.
- cnt width is $clog2(N). It wraps at N-1 to 0.
- FSM state IDLE:
  - cnt is held at 0 and no sampling occurs.
  - On sym_rise: go to RUN, set cnt<=0, and latch mode_l<=mode.
- FSM state RUN:
  - If sym_rise: cnt<=0 and mode_l<=mode.
  - Else if cnt==N-1: cnt<=0 and mode_l<=mode (free-run wrap, no new edge needed).
  - Else: cnt<=cnt+1.
- Sample points use integer division. When cnt equals a sample point, the matching shadow register captures multiplexed_data.
  - mode_l=1: S1=N/2.
  - mode_l=2: S1=N/4; S2=N/2+N/4.
  - mode_l=3: S1=N/6; S2=N/3+N/6; S3=2N/3+N/6.
  - For N=100 these are 50 / 25,75 / 16,49,82.
- Transfer: when cnt==N-1 in RUN and mode_l!=0:
  - ds*_out<=shadows on the next edge, with ds_valid=1 for exactly that cycle.
  - Streams unused in mode_l are driven 0 (e.g. mode 1 gives ds2_out=ds3_out=0).
  - Latency is 1 cycle from cnt==N-1 to ds_valid.
- mode_l=0: no sampling and no transfer. Outputs hold their last values and ds_valid stays 0.
- A mode change mid-symbol has no effect until the next symbol start or wrap.
- sym_rise in the same cycle as cnt==N-1: the transfer happens and the counter restarts. This is a normal aligned symbol.
- Early sym_rise (cnt!=N-1 in RUN): the partial symbol's shadows are discarded, with no transfer and no ds_valid. The counter restarts at 0. Shadows are cleared to 0.
- Reset asserted mid-symbol: immediate return to the reset state. The first valid output comes one full symbol after the first post-reset sym_rise.

Optional Feature:
Macro DEMUX_SYNC_CHECK_EN.
- With the macro: sync_err is set to 1 on any early sym_rise in RUN. It is sticky until rst, and has no effect on the data path.
- Without the macro: sync_err is tied 0 and no check logic is built. The port list is unchanged.

Decomposition:
- Package data_stream_pkg holds:
  - the mode_t enum: MODE_OFF=0, MODE_1=1, MODE_2=2, MODE_3=3, shared with the multiplexer;
  - a function cycles_per_symbol(clk_f, symbol_clk_f);
  - a sample-point function slot_sample(n, mode, slot) returning the S values above.
- One sub-module, symbol_timer, holds sym_prev, sym_rise, the IDLE/RUN FSM, cnt, mode_l and the early-edge detect. It outputs cnt, mode_l, sym_end and early_edge.
- The top level holds the shadow registers, the output registers and sync_err.

Test Plan:
All scenarios use N=100 unless stated.
1. Reset, then a 1 MHz symbol_clk with mode=3, and the upstream multiplexer driving ds1=0xA1, ds2=0xB2, ds3=0xC3 -> ds_valid pulses once per 100 cycles, with ds1_out=0xA1, ds2_out=0xB2, ds3_out=0xC3.
2. mode=2 with ds1=0x11, ds2=0x22 -> ds1_out=0x11, ds2_out=0x22, ds3_out=0. mode=1 with ds1=0x5A -> ds1_out=0x5A, others 0, sampled at cnt=50.
3. mode switched from 2 to 3 at cnt=40 -> the current symbol is still decoded as mode 2, and the next symbol is decoded as mode 3.
4. symbol_clk edge injected at cnt=60 -> no ds_valid for that symbol and the counter restarts at 0. sync_err=1 with DEMUX_SYNC_CHECK_EN, 0 without. The next aligned symbol decodes correctly.
5. rst pulsed low at cnt=30 -> all outputs are 0 immediately. ds_valid stays 0 until one full symbol after the next symbol_clk rise.
6. mode=0 for 3 symbols after valid data -> ds_valid stays 0 and outputs hold their previous values.
